// File: rtl/grid_renderer.sv
// N x N game-board pixel renderer: counter-based grid trackers, frame-latched board,
// win highlighting; blinking cursor built only when GRID_RENDER_CURSOR_EN is defined.
module grid_renderer #(
    parameter int N            = 3,
    parameter int LEFT_EDGE    = 150,
    parameter int TOP_EDGE     = 70,
    parameter int LINE_WIDTH   = 10,
    parameter int CELL_WIDTH   = 100,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                      iVGA_CLK,
    input  logic                      iRST_n,
    input  logic [9:0]                col,
    input  logic [8:0]                row,
    input  logic                      iBLANK_n,
    input  logic                      iHS,
    input  logic                      iVS,
    input  logic [2*N*N-1:0]          board,
    input  logic [N*N-1:0]            win_mask,
    input  logic [$clog2(N*N)-1:0]    cursor,
    output logic [3:0]                oVGA_R,
    output logic [3:0]                oVGA_G,
    output logic [3:0]                oVGA_B,
    output logic                      oHS,
    output logic                      oVS,
    output logic                      oBLANK_n
);

    localparam int CELLS   = N * N;
    localparam int SEG_MAX = (LINE_WIDTH > CELL_WIDTH) ? LINE_WIDTH : CELL_WIDTH;
    localparam int SEGW    = $clog2(SEG_MAX + 1);
    localparam int CNTW    = $clog2(N + 2);

    localparam logic [SEGW-1:0] LINE_LAST = SEGW'(LINE_WIDTH - 1);
    localparam logic [SEGW-1:0] CELL_LAST = SEGW'(CELL_WIDTH - 1);
    localparam logic [CNTW-1:0] LAST_LINE = CNTW'(N);
    localparam logic [9:0]      LEFT_COL  = 10'(LEFT_EDGE);
    localparam logic [8:0]      TOP_ROW   = 9'(TOP_EDGE);

    typedef enum logic [1:0] {SEG_OUT, SEG_LINE, SEG_CELL} seg_e;

    typedef struct packed {
        seg_e            state;
        logic [SEGW-1:0] cnt;
        logic [CNTW-1:0] lines;
        logic [CNTW-1:0] idx;
    } trk_t;

    localparam trk_t TRK_RESET = '{state: SEG_OUT, cnt: '0, lines: '0, idx: '0};

    // One step of a line/cell tracker; the same machine serves both axes.
    function automatic trk_t trk_step(input trk_t cur, input logic start);
        trk_t nxt;
        nxt = cur;
        if (start) begin
            nxt = '{state: SEG_LINE, cnt: '0, lines: '0, idx: '0};
        end else begin
            case (cur.state)
                SEG_LINE: begin
                    if (cur.cnt == LINE_LAST) begin
                        nxt.cnt   = '0;
                        nxt.lines = cur.lines + 1'b1;
                        nxt.state = (cur.lines == LAST_LINE) ? SEG_OUT : SEG_CELL;
                    end else begin
                        nxt.cnt = cur.cnt + 1'b1;
                    end
                end
                SEG_CELL: begin
                    if (cur.cnt == CELL_LAST) begin
                        nxt.cnt   = '0;
                        nxt.idx   = cur.idx + 1'b1;
                        nxt.state = SEG_LINE;
                    end else begin
                        nxt.cnt = cur.cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        return nxt;
    endfunction

    function automatic logic [11:0] cell_colour(input logic [1:0] code, input logic win,
                                                input logic hit);
        logic [11:0] c;
        c = 12'h000;
        if (hit)                 c = 12'hFF0;
        else if (code == 2'b10)  c = win ? 12'hF00 : 12'h700;
        else if (code == 2'b11)  c = win ? 12'h00F : 12'h007;
        return c;
    endfunction

    trk_t                h_q, h_d, v_q, v_d;
    logic [8:0]          row_prev_q;
    logic                blank_d1_q, hs_d1_q, vs_d1_q;
    logic [2*CELLS-1:0]  board_sh_q, board_sh_d;
    logic [CELLS-1:0]    win_sh_q, win_sh_d;
    logic [11:0]         rgb_q, rgb_d;
    logic                hs_q, vs_q, blank_q;
    logic                latch;
    logic                cursor_hit;
    int                  cell_k;
    int                  cell_sel;

    assign latch    = vs_d1_q & ~iVS;
    assign cell_k   = int'(v_q.idx) * N + int'(h_q.idx);
    assign cell_sel = (cell_k < CELLS) ? cell_k : 0;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        h_d        = trk_step(h_q, col == LEFT_COL);
        v_d        = v_q;
        board_sh_d = board_sh_q;
        win_sh_d   = win_sh_q;
        rgb_d      = 12'h070;

        if (row != row_prev_q) v_d = trk_step(v_q, row == TOP_ROW);

        if (latch) begin
            board_sh_d = board;
            win_sh_d   = win_mask;
        end

        if (!blank_d1_q) begin
            rgb_d = 12'h000;
        end else if ((h_q.state == SEG_LINE && v_q.state != SEG_OUT) ||
                     (v_q.state == SEG_LINE && h_q.state != SEG_OUT)) begin
            rgb_d = 12'hFFF;
        end else if (h_q.state == SEG_CELL && v_q.state == SEG_CELL) begin
            rgb_d = cell_colour(board_sh_q[2*cell_sel +: 2], win_sh_q[cell_sel], cursor_hit);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            h_q        <= TRK_RESET;
            v_q        <= TRK_RESET;
            row_prev_q <= '0;
            blank_d1_q <= 1'b0;
            hs_d1_q    <= 1'b1;
            vs_d1_q    <= 1'b1;
            // NOTE: shadow board registers are reset because the renderer reads them before the first latch.
            board_sh_q <= '0;
            win_sh_q   <= '0;
            rgb_q      <= '0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            blank_q    <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            row_prev_q <= row;
            blank_d1_q <= iBLANK_n;
            hs_d1_q    <= iHS;
            vs_d1_q    <= iVS;
            board_sh_q <= board_sh_d;
            win_sh_q   <= win_sh_d;
            rgb_q      <= rgb_d;
            hs_q       <= hs_d1_q;
            vs_q       <= vs_d1_q;
            blank_q    <= blank_d1_q;
        end
    end

`ifdef GRID_RENDER_CURSOR_EN
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);

    logic [$clog2(CELLS)-1:0] cursor_sh_q, cursor_sh_d;
    logic [FCW-1:0]           frame_q, frame_d;
    logic                     blink_q, blink_d;

    always_comb begin
        cursor_sh_d = cursor_sh_q;
        frame_d     = frame_q;
        blink_d     = blink_q;
        if (latch) begin
            cursor_sh_d = cursor;
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
        // Out-of-range cursor values never equal a real cell index.
        cursor_hit = blink_q && (int'(cursor_sh_q) == cell_sel);
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            cursor_sh_q <= '0;
            frame_q     <= '0;
            blink_q     <= 1'b0;
        end else begin
            cursor_sh_q <= cursor_sh_d;
            frame_q     <= frame_d;
            blink_q     <= blink_d;
        end
    end
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_cursor;
    assign unused_cursor = ^cursor;
    assign cursor_hit    = 1'b0;
`endif

    assign oVGA_R   = rgb_q[11:8];
    assign oVGA_G   = rgb_q[7:4];
    assign oVGA_B   = rgb_q[3:0];
    assign oHS      = hs_q;
    assign oVS      = vs_q;
    assign oBLANK_n = blank_q;

endmodule
